mips_multicycle_ctl: RTL and testbench
======================================

Name: mips_multicycle_ctl

Overview:
- Main control unit for the multicycle MIPS datapath; the stage directly upstream of the ALU control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and muxes, and produces the 3-bit ALU operation class (To_ctl_ALU) that the ALU control decoder consumes.
- Handles a memory-ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- OP_R, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word.
- OP_SW, 6'b101011, store word.
- OP_BEQ, 6'b000100, branch equal.
- OP_BNE, 6'b000101, branch not equal.
- OP_J, 6'b000010, jump.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- OpCode  input  6  instr[31:26] from instruction register.
- Zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- PCWrite  output  1  final PC enable, including the resolved branch condition.
- IorD  output  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data select: 1=MDR.
- RegDst  output  1  register write destination: 1=rd, 0=rt.
- RegWrite  output  1  register file write enable.
- ALUSrcA  output  1  ALU A select: 0=PC, 1=rs.
- ALUSrcB  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-extended imm, 11=imm<<2.
- PCSource  output  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- To_ctl_ALU  output  3  ALU operation class: 000=R-type (use funct), 001=add for LW/PC, 010=add for SW, 100=subtract for branch.
- illegal_op  output  1  sticky illegal-opcode flag.
- state_dbg  output  4  current state encoding.
- instr_retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE(0), all control outputs 0, To_ctl_ALU=001, illegal_op=0, instr_retired=0, op_q=0.
  - Reset asserted mid-instruction aborts it immediately; no partial write survives.
- Output style: Moore decode of the registered state. Only PCWrite in BRANCH depends on Zero.
- op_q latches OpCode on the DECODE cycle. All later decisions use op_q.
- States (encoding) and transitions:
  - IDLE(0): all outputs 0. -> FETCH next cycle.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, To_ctl_ALU=001, PCSource=00. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; -> DECODE when 1. PC advances exactly once per fetch.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, To_ctl_ALU=001.
    - -> MEMADR for LW/SW.
    - -> EXEC for R-type.
    - -> BRANCH for BEQ/BNE.
    - -> JUMP for J.
    - -> TRAP for any other opcode.
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, To_ctl_ALU=001 (LW) or 010 (SW). -> MEMRD if LW, MEMWR if SW.
  - MEMRD(4): MemRead=1, IorD=1. Stay while mem_ready=0; -> MEMWB.
  - MEMWB(5): RegWrite=1, MemtoReg=1, RegDst=0. Retire. -> FETCH.
  - MEMWR(6): MemWrite=1, IorD=1, held high while waiting. Stay while mem_ready=0; retire and -> FETCH when 1.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, To_ctl_ALU=000. -> RWB.
  - RWB(8): RegWrite=1, RegDst=1, MemtoReg=0. Retire. -> FETCH.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, To_ctl_ALU=100, PCSource=01.
    - PCWrite=Zero for BEQ; PCWrite=~Zero for BNE.
    - Retire. -> FETCH.
  - JUMP(10): PCWrite=1, PCSource=10. Retire. -> FETCH.
  - TRAP(11): illegal_op=1 (sticky). All enables 0. Remain until reset. No retire.
- Unused encodings 12-15: -> IDLE next cycle, outputs 0.
- instr_retired: +1 on each retire cycle, i.e. the cycle the FSM leaves for FETCH. A retire in MEMWR requires mem_ready=1. Wraps modulo 2^CNT_W silently.
- Latency in cycles with mem_ready always 1:
  - LW=5, SW=4, R-type=4, BEQ/BNE=3, J=3.
  - Each mem_ready=0 cycle adds one cycle in FETCH/MEMRD/MEMWR.

Test Plan:
- Reset release, mem_ready=1, OpCode=000000 -> state seq 0,1,2,7,8,1. To_ctl_ALU=000 in EXEC. RegWrite=1, RegDst=1 in RWB. instr_retired=1.
- OpCode=100011, mem_ready low 2 cycles in MEMRD -> MEMRD held 3 cycles with MemRead=1, IorD=1. To_ctl_ALU=001 in MEMADR. MEMWB asserts RegWrite, MemtoReg. Total 7 cycles from FETCH.
- OpCode=000101 with Zero=0 then repeat with Zero=1 -> PCWrite=1 then 0 in BRANCH. To_ctl_ALU=100, PCSource=01. instr_retired +2.
- OpCode=101011, mem_ready=0 for first 3 FETCH cycles -> IRWrite/PCWrite stay 0 until mem_ready=1 and pulse exactly once. To_ctl_ALU=010 in MEMADR. MemWrite=1 in MEMWR.
- OpCode=111111 -> TRAP (state_dbg=11), illegal_op=1 held 10+ cycles, instr_retired unchanged. rst_n=0 clears to IDLE with all outputs 0.
- Preload instr_retired to all-ones via 2^CNT_W-1 retires (CNT_W=4 build: 15 J instructions), one more J -> instr_retired=0. Assert rst_n low during MEMWR -> MemWrite drops asynchronously.

Source files
------------

// File: rtl/mips_multicycle_ctl_if.sv
// Control bundle between the multicycle MIPS main controller and its datapath.
// master: the controller. It takes OpCode/Zero/mem_ready and drives the enables,
//         the mux selects, the ALU class, and the debug/status outputs.
// slave:  the datapath side, with the opposite directions.
interface mips_multicycle_ctl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       OpCode;
    logic             Zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       PCSource;
    logic [2:0]       To_ctl_ALU;
    logic             illegal_op;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instr_retired;

    modport master (
        input  OpCode, Zero, mem_ready,
        output PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, To_ctl_ALU, illegal_op,
               state_dbg, instr_retired
    );

    modport slave (
        output OpCode, Zero, mem_ready,
        input  PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, To_ctl_ALU, illegal_op,
               state_dbg, instr_retired
    );
endinterface

// File: rtl/mips_multicycle_ctl.sv
// Main control FSM for the multicycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// Produces the datapath enables and mux selects, and the 3-bit ALU operation
// class for the ALU control decoder. Also keeps a sticky illegal-opcode flag and
// a retired-instruction counter.
// Ports: clk, rst_n (async, active-low), and bus (mips_multicycle_ctl_if.master).
module mips_multicycle_ctl #(
    parameter int unsigned CNT_W  = 32,
    parameter logic [5:0]  OP_R   = 6'b000000,
    parameter logic [5:0]  OP_LW  = 6'b100011,
    parameter logic [5:0]  OP_SW  = 6'b101011,
    parameter logic [5:0]  OP_BEQ = 6'b000100,
    parameter logic [5:0]  OP_BNE = 6'b000101,
    parameter logic [5:0]  OP_J   = 6'b000010
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_multicycle_ctl_if.master   bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_RWB    = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JUMP   = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_ADDSW = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b100;

    logic [3:0]       state;
    logic [3:0]       state_n;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic             retire_c;
    logic             pc_write_c;
    logic             iord_c;
    logic             mem_read_c;
    logic             mem_write_c;
    logic             ir_write_c;
    logic             mem_to_reg_c;
    logic             reg_dst_c;
    logic             reg_write_c;
    logic             alu_src_a_c;
    logic [1:0]       alu_src_b_c;
    logic [1:0]       pc_source_c;
    logic [2:0]       alu_op_c;

    // State register. An async reset aborts any in-flight access at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic and Moore output decode. PCWrite in BRANCH is the
    // only output that also looks at Zero. FETCH also gates IRWrite/PCWrite
    // with mem_ready.
    always_comb begin
        state_n      = state;
        retire_c     = 1'b0;
        pc_write_c   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_dst_c    = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        pc_source_c  = 2'b00;
        alu_op_c     = ALU_ADD;

        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                // Load IR and advance PC only in the cycle the read returns.
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b_c = 2'b11;
                // op_q is not valid until the end of this cycle, so decode the live opcode here.
                case (bus.OpCode)
                    OP_LW, OP_SW:   state_n = S_MEMADR;
                    OP_R:           state_n = S_EXEC;
                    OP_BEQ, OP_BNE: state_n = S_BRANCH;
                    OP_J:           state_n = S_JUMP;
                    default:        state_n = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                if (op_q == OP_SW) begin
                    alu_op_c = ALU_ADDSW;
                    state_n  = S_MEMWR;
                end else begin
                    state_n  = S_MEMRD;
                end
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (bus.mem_ready) begin
                    state_n = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                retire_c     = 1'b1;
                state_n      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (bus.mem_ready) begin
                    retire_c = 1'b1;
                    state_n  = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_RTYPE;
                state_n     = S_RWB;
            end
            S_RWB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                retire_c    = 1'b1;
                state_n     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_source_c = 2'b01;
                pc_write_c  = (op_q == OP_BNE) ? ~bus.Zero : bus.Zero;
                retire_c    = 1'b1;
                state_n     = S_FETCH;
            end
            S_JUMP: begin
                pc_write_c  = 1'b1;
                pc_source_c = 2'b10;
                retire_c    = 1'b1;
                state_n     = S_FETCH;
            end
            S_TRAP: begin
                state_n = S_TRAP;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Opcode captured in DECODE. Every later state decides from this copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= 6'd0;
        end else if (state == S_DECODE) begin
            op_q <= bus.OpCode;
        end
    end

    // Sticky illegal-opcode flag, set on the edge that enters TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_n == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Retired-instruction counter; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= '0;
        end else if (retire_c) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.PCWrite       = pc_write_c;
    assign bus.IorD          = iord_c;
    assign bus.MemRead       = mem_read_c;
    assign bus.MemWrite      = mem_write_c;
    assign bus.IRWrite       = ir_write_c;
    assign bus.MemtoReg      = mem_to_reg_c;
    assign bus.RegDst        = reg_dst_c;
    assign bus.RegWrite      = reg_write_c;
    assign bus.ALUSrcA       = alu_src_a_c;
    assign bus.ALUSrcB       = alu_src_b_c;
    assign bus.PCSource      = pc_source_c;
    assign bus.To_ctl_ALU    = alu_op_c;
    assign bus.illegal_op    = illegal_q;
    assign bus.state_dbg     = state;
    assign bus.instr_retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctl.sv
// Scoreboard bench for mips_multicycle_ctl, built with CNT_W=4 so the retire
// counter wraps quickly. Each instruction is expanded into per-cycle stimulus
// and expected state/output records. The records are popped and compared at
// every falling edge.
module tb_mips_multicycle_ctl;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] OP_GARB = 6'b110011;

    typedef struct packed {
        logic [5:0] op;
        logic       zero;
        logic       mr;
    } stim_t;

    typedef struct packed {
        logic [3:0]       st;
        logic [12:0]      ctl;
        logic [2:0]       alu;
        logic             ill;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mips_multicycle_ctl_if #(.CNT_W(CNT_W)) bus ();

    mips_multicycle_ctl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    stim_t            stim_q[$];
    exp_t             exp_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [CNT_W-1:0] m_ret;
    logic             m_ill;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, expv);
        end
    endtask

    // Control vector order: PCWrite IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB PCSource
    function automatic logic [12:0] ctlv(input logic pcw, input logic iord, input logic mrd,
                                         input logic mwr, input logic irw, input logic m2r,
                                         input logic rdst, input logic rw, input logic sa,
                                         input logic [1:0] sb, input logic [1:0] ps);
        return {pcw, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps};
    endfunction

    function automatic logic [12:0] obs_ctl();
        return {bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                bus.ALUSrcB, bus.PCSource};
    endfunction

    task automatic push(input logic [5:0] op, input logic zero, input logic mr,
                        input logic [3:0] st, input logic [12:0] ctl,
                        input logic [2:0] alu, input logic retire);
        stim_t s;
        exp_t  e;
        s.op = op; s.zero = zero; s.mr = mr;
        e.st = st; e.ctl = ctl; e.alu = alu; e.ill = m_ill; e.ret = m_ret;
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (retire) m_ret = m_ret + CNT_W'(1);
    endtask

    task automatic push_idle();
        push(6'd0, 1'b0, 1'b1, 4'd0, 13'd0, 3'b001, 1'b0);
    endtask

    // Expand one instruction, starting in FETCH. fw = FETCH wait cycles.
    // mw = memory wait cycles, or the number of TRAP cycles for an illegal op.
    task automatic gen_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
        for (int i = 0; i < fw; i++)
            push(op, z, 1'b0, 4'd1, ctlv(0,0,1,0,0,0,0,0,0,2'b01,2'b00), 3'b001, 1'b0);
        push(op, z, 1'b1, 4'd1, ctlv(1,0,1,0,1,0,0,0,0,2'b01,2'b00), 3'b001, 1'b0);
        push(op, z, 1'b1, 4'd2, ctlv(0,0,0,0,0,0,0,0,0,2'b11,2'b00), 3'b001, 1'b0);
        case (op)
            OP_LW: begin
                push(OP_GARB, z, 1'b1, 4'd3, ctlv(0,0,0,0,0,0,0,0,1,2'b10,2'b00), 3'b001, 1'b0);
                for (int i = 0; i < mw; i++)
                    push(OP_GARB, z, 1'b0, 4'd4, ctlv(0,1,1,0,0,0,0,0,0,2'b00,2'b00), 3'b001, 1'b0);
                push(OP_GARB, z, 1'b1, 4'd4, ctlv(0,1,1,0,0,0,0,0,0,2'b00,2'b00), 3'b001, 1'b0);
                push(OP_GARB, z, 1'b1, 4'd5, ctlv(0,0,0,0,0,1,0,1,0,2'b00,2'b00), 3'b001, 1'b1);
            end
            OP_SW: begin
                push(OP_GARB, z, 1'b1, 4'd3, ctlv(0,0,0,0,0,0,0,0,1,2'b10,2'b00), 3'b010, 1'b0);
                for (int i = 0; i < mw; i++)
                    push(OP_GARB, z, 1'b0, 4'd6, ctlv(0,1,0,1,0,0,0,0,0,2'b00,2'b00), 3'b001, 1'b0);
                push(OP_GARB, z, 1'b1, 4'd6, ctlv(0,1,0,1,0,0,0,0,0,2'b00,2'b00), 3'b001, 1'b1);
            end
            OP_R: begin
                push(OP_GARB, z, 1'b1, 4'd7, ctlv(0,0,0,0,0,0,0,0,1,2'b00,2'b00), 3'b000, 1'b0);
                push(OP_GARB, z, 1'b1, 4'd8, ctlv(0,0,0,0,0,0,1,1,0,2'b00,2'b00), 3'b001, 1'b1);
            end
            OP_BEQ, OP_BNE: begin
                logic taken;
                taken = (op == OP_BNE) ? ~z : z;
                push(OP_GARB, z, 1'b1, 4'd9, ctlv(taken,0,0,0,0,0,0,0,1,2'b00,2'b01), 3'b100, 1'b1);
            end
            OP_J: begin
                push(OP_GARB, z, 1'b1, 4'd10, ctlv(1,0,0,0,0,0,0,0,0,2'b00,2'b10), 3'b001, 1'b1);
            end
            default: begin
                m_ill = 1'b1;
                for (int i = 0; i < mw; i++)
                    push(OP_GARB, z, 1'b1, 4'd11, 13'd0, 3'b001, 1'b0);
            end
        endcase
    endtask

    // Drive one queued cycle after the rising edge and compare at the falling edge.
    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            stim_t s;
            exp_t  e;
            if (stim_q.size() == 0 || exp_q.size() == 0) break;
            s = stim_q.pop_front();
            bus.OpCode    = s.op;
            bus.Zero      = s.zero;
            bus.mem_ready = s.mr;
            @(negedge clk);
            e = exp_q.pop_front();
            check("state", 32'(bus.state_dbg), 32'(e.st));
            check("ctl",   32'(obs_ctl()), 32'(e.ctl));
            check("alu",   32'(bus.To_ctl_ALU), 32'(e.alu));
            check("illegal", 32'(bus.illegal_op), 32'(e.ill));
            check("retired", 32'(bus.instr_retired), 32'(e.ret));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_all();
        run_cycles(stim_q.size());
        check("q_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.OpCode    = 6'd0;
        bus.Zero      = 1'b0;
        bus.mem_ready = 1'b1;
        m_ret         = '0;
        m_ill         = 1'b0;

        // Held in reset: IDLE, all enables low, ALU class defaults to add
        push_idle();
        push_idle();
        run_all();

        rst_n = 1'b1;
        push_idle();
        gen_instr(OP_R,   1'b0, 0, 0);
        gen_instr(OP_LW,  1'b0, 0, 2);
        gen_instr(OP_BNE, 1'b0, 0, 0);
        gen_instr(OP_BNE, 1'b1, 0, 0);
        gen_instr(OP_BEQ, 1'b1, 0, 0);
        gen_instr(OP_BEQ, 1'b0, 0, 0);
        gen_instr(OP_SW,  1'b0, 3, 1);
        run_all();

        // Seven retired so far; nine jumps take the 4-bit counter through 15 to 0
        for (int i = 0; i < 9; i++) gen_instr(OP_J, 1'b0, 0, 0);
        run_all();
        check("wrap_cnt", 32'(bus.instr_retired), 32'd0);

        // Store stalled in MEMWR, then reset mid-access
        gen_instr(OP_SW, 1'b0, 0, 3);
        run_cycles(3);
        bus.mem_ready = 1'b0;
        check("memwr_state", 32'(bus.state_dbg), 32'd6);
        check("memwr_hold", 32'(bus.MemWrite), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        check("rst_state", 32'(bus.state_dbg), 32'd0);
        check("rst_ctl", 32'(obs_ctl()), 32'd0);
        stim_q.delete();
        exp_q.delete();
        m_ret = '0;
        m_ill = 1'b0;

        // Illegal opcode: TRAP held, flag sticky, no retire
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_idle();
        gen_instr(OP_BAD, 1'b0, 0, 12);
        run_all();
        check("trap_state", 32'(bus.state_dbg), 32'd11);
        check("trap_sticky", 32'(bus.illegal_op), 32'd1);
        check("trap_retired", 32'(bus.instr_retired), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("trap_rst_state", 32'(bus.state_dbg), 32'd0);
        check("trap_rst_illegal", 32'(bus.illegal_op), 32'd0);
        check("trap_rst_ctl", 32'(obs_ctl()), 32'd0);
        check("trap_rst_alu", 32'(bus.To_ctl_ALU), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
